// File: rtl/fdiv_prog.sv
// Runtime-programmable clock-enable divider with double-buffered divisor.
// New divisors are applied only at a period boundary (or restart) so Fout never glitches.
module fdiv_prog #(
    parameter int unsigned W       = 32,
    parameter int unsigned DEF_DIV = 10
) (
    input  logic         Fin,
    input  logic         reset,
    input  logic         en,
    input  logic         restart,
    input  logic [W-1:0] div_in,
    input  logic         div_load,
    input  logic         mode,
    output logic         Fout,
    output logic         tick,
    output logic         div_err,
    output logic [W-1:0] cnt_out
);

    localparam logic [W-1:0] DefDiv = W'(DEF_DIV);

    logic [W-1:0] cnt;
    logic [W-1:0] act_div;
    logic [W-1:0] sh_div;
    logic         pend;
    logic [W:0]   hi;
    logic         term;
    logic         div_small;

    // High-phase length kept one bit wider so a divisor of 2^W-1 does not wrap.
    assign hi        = ({1'b0, act_div} + (W+1)'(1)) >> 1;
    assign term      = (cnt == act_div - W'(1));
    assign div_small = (div_in < W'(2));
    assign cnt_out   = cnt;

    always_ff @(posedge Fin) begin
        if (reset) begin
            cnt     <= '0;
            act_div <= DefDiv;
            sh_div  <= DefDiv;
            pend    <= 1'b0;
            Fout    <= 1'b0;
            tick    <= 1'b0;
            div_err <= 1'b0;
        end else begin
            tick    <= 1'b0;
            div_err <= 1'b0;

            if (restart) begin
                cnt <= '0;
                if (pend) begin
                    act_div <= sh_div;
                    pend    <= 1'b0;
                end
            end else if (en) begin
                if (term) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    if (pend) begin
                        act_div <= sh_div;
                        pend    <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + W'(1);
                end
            end

            if (en || restart) begin
                Fout <= mode ? term : ({1'b0, cnt} < hi);
            end

            // Placed last so a load coincident with a boundary re-arms pend for the next one.
            if (div_load) begin
                sh_div  <= div_small ? W'(2) : div_in;
                pend    <= 1'b1;
                div_err <= div_small;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_prog.sv
// Scoreboard bench for fdiv_prog: a cycle model pushes expected outputs per driven cycle,
// a checker pops them after each edge and compares a 32-bit and a 4-bit instance.
module tb_fdiv_prog;

    logic        Fin = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        restart = 1'b0;
    logic        div_load = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] div_in = '0;

    logic        fout32, tick32, err32;
    logic [31:0] cnt32;
    logic        fout4, tick4, err4;
    logic [3:0]  cnt4;

    always #5 Fin = ~Fin;

    fdiv_prog #(.W(32), .DEF_DIV(10)) u_dut32 (
        .Fin      (Fin),
        .reset    (reset),
        .en       (en),
        .restart  (restart),
        .div_in   (div_in),
        .div_load (div_load),
        .mode     (mode),
        .Fout     (fout32),
        .tick     (tick32),
        .div_err  (err32),
        .cnt_out  (cnt32)
    );

    fdiv_prog #(.W(4), .DEF_DIV(10)) u_dut4 (
        .Fin      (Fin),
        .reset    (reset),
        .en       (en),
        .restart  (restart),
        .div_in   (div_in[3:0]),
        .div_load (div_load),
        .mode     (mode),
        .Fout     (fout4),
        .tick     (tick4),
        .div_err  (err4),
        .cnt_out  (cnt4)
    );

    typedef struct {
        logic [31:0] cnt;
        logic        fout;
        logic        tick;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t got_exp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] m_cnt = '0, m_act = 32'd10, m_sh = 32'd10;
    logic        m_pend = 1'b0, m_fout = 1'b0, m_tick = 1'b0, m_err = 1'b0;
    logic        cur_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
    task automatic step(input logic r, input logic e, input logic rs, input logic ld,
                        input logic [31:0] d, input logic md);
        exp_t        x;
        logic        t;
        logic [32:0] h;
        logic [31:0] n_cnt, n_act, n_sh;
        logic        n_pend, n_fout;
        @(negedge Fin);
        reset = r; en = e; restart = rs; div_load = ld; div_in = d; mode = md;
        if (r) begin
            m_cnt = '0; m_act = 32'd10; m_sh = 32'd10; m_pend = 1'b0;
            m_fout = 1'b0; m_tick = 1'b0; m_err = 1'b0;
        end else begin
            t = (m_cnt == m_act - 32'd1);
            h = ({1'b0, m_act} + 33'd1) >> 1;
            n_cnt = m_cnt; n_act = m_act; n_sh = m_sh; n_pend = m_pend; n_fout = m_fout;
            m_tick = 1'b0;
            m_err  = 1'b0;
            if (rs || (e && t)) begin
                n_cnt = '0;
                if (m_pend) begin
                    n_act  = m_sh;
                    n_pend = 1'b0;
                end
                m_tick = !rs;
            end else if (e) begin
                n_cnt = m_cnt + 32'd1;
            end
            if (e || rs) n_fout = md ? t : ({1'b0, m_cnt} < h);
            if (ld) begin
                n_sh   = (d < 32'd2) ? 32'd2 : d;
                n_pend = 1'b1;
                m_err  = (d < 32'd2);
            end
            m_cnt = n_cnt; m_act = n_act; m_sh = n_sh; m_pend = n_pend; m_fout = n_fout;
        end
        x.cnt = m_cnt; x.fout = m_fout; x.tick = m_tick; x.err = m_err;
        sb.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, cur_mode);
    endtask

    task automatic run_to(input logic [31:0] c);
        for (int i = 0; i < 64; i++) begin
            if (m_cnt == c) break;
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, cur_mode);
        end
    endtask

    task automatic load(input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b1, d, cur_mode);
    endtask

    always @(posedge Fin) begin
        #1;
        cyc++;
        if (sb.size() > 0) begin
            got_exp = sb.pop_front();
            check("cnt32",  cnt32,          got_exp.cnt);
            check("fout32", 32'(fout32),    32'(got_exp.fout));
            check("tick32", 32'(tick32),    32'(got_exp.tick));
            check("err32",  32'(err32),     32'(got_exp.err));
            check("cnt4",   32'(cnt4),      got_exp.cnt);
            check("fout4",  32'(fout4),     32'(got_exp.fout));
            check("tick4",  32'(tick4),     32'(got_exp.tick));
            check("err4",   32'(err4),      32'(got_exp.err));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, default divisor 10, square wave
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 1'b0);
        run(25);

        // 2: load mid-period, then a load coincident with the terminal count
        run_to(32'd3);
        load(32'd5);
        run(20);
        run_to(m_act - 32'd1);
        load(32'd4);
        run(14);

        // 3: clamped divisors
        load(32'd1);
        run(8);
        load(32'd0);
        run(8);

        // 4: enable freeze and restart, restart with pending load and coincident load
        load(32'd10);
        run(3);
        run_to(32'd4);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, cur_mode);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd6, cur_mode);
        run(14);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, cur_mode);
        run(4);
        load(32'd3);
        run(2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'd7, cur_mode);
        run(16);

        // 5: pulse mode with divisor 4, then widest 4-bit divisor in square mode
        cur_mode = 1'b1;
        load(32'd4);
        run(16);
        cur_mode = 1'b0;
        load(32'd15);
        run(40);

        // 6: reset with a load pending
        run_to(32'd2);
        load(32'd7);
        run_to(32'd6);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        run(22);

        @(negedge Fin);
        @(negedge Fin);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
